// File: rtl/ahb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_responder
// Purpose  : AHB-Lite slave in front of a byte-lane-writable 32-bit SRAM
//            array. Optional wait states, two-cycle ERROR response for
//            out-of-range / oversize / misaligned transfers, and write-to-read
//            forwarding so a read right behind a write to the same word
//            returns the merged new data.
// Revision : 1.0  initial release
// ============================================================================
module ahb_sram_responder #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          ADDR_W   = $clog2(MEM_WORDS);
  localparam logic [30:0] C_WORDS  = 31'(MEM_WORDS);
  localparam logic [3:0]  C_WAITS  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Storage array; deliberately left out of reset
  logic [31:0] mem [MEM_WORDS];

  state_t              state_q, state_d;
  logic [3:0]          cnt_q,   cnt_d;
  logic [ADDR_W-1:0]   idx_q,   idx_d;
  logic [3:0]          be_q,    be_d;
  logic                wr_q,    wr_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                ready_int;
  logic                accept;
  logic                xfer_err;
  logic [ADDR_W-1:0]   acc_idx;
  logic [3:0]          acc_be;
  logic                mem_we;
  logic [31:0]         wr_merge;

  // HBURST is irrelevant (per-beat HADDR addressing) and HTRANS[0] only
  // distinguishes SEQ from NONSEQ, which is treated identically.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  // Ready while idle or in the second error cycle; error response in ERR1/ERR2
  assign ready_int = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign HREADYOUT = ready_int;
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign HRDATA    = rdata_q;

  // A valid write commits on the final edge of its data phase
  assign mem_we = wr_q && ready_int;

  // Address-phase decode: acceptance, error classification and byte lanes
  always_comb begin
    accept   = HSEL && HREADY && HTRANS[1] && ready_int;
    xfer_err = ({1'b0, HADDR[31:2]} >= C_WORDS)
             || (HSIZE > 3'b010)
             || ((HSIZE == 3'b001) && HADDR[0])
             || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
    acc_idx  = HADDR[ADDR_W+1:2];
    case (HSIZE)
      3'b000:  acc_be = 4'b0001 << HADDR[1:0];
      3'b001:  acc_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: acc_be = 4'b1111;
    endcase
  end

  // Merge write data into the stored word on the enabled little-endian lanes
  always_comb begin
    wr_merge = mem[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) wr_merge[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // Next-state and data-phase bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        // Current data phase (if any) finishes this cycle
        state_d = ST_IDLE;
        wr_d    = 1'b0;
        if (accept) begin
          idx_d = acc_idx;
          be_d  = acc_be;
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else begin
            wr_d = HWRITE;
            if (WAIT_STATES != 0) begin
              state_d = ST_WAIT;
              cnt_d   = C_WAITS;
            end
            if (!HWRITE) begin
              // Forward a write committing at this same edge to avoid stale data
              if (mem_we && (idx_q == acc_idx)) rdata_d = wr_merge;
              else                              rdata_d = mem[acc_idx];
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control/datapath registers with asynchronous active-low reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM write port
  always_ff @(posedge HCLK) begin
    if (mem_we) mem[idx_q] <= wr_merge;
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_responder
// Purpose  : Self-checking bench: two responders (0 and 3 wait states) driven
//            by a pipelined AHB master, checked against a word-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_sram_responder;

  localparam int WORDS0 = 256;
  localparam int WORDS3 = 64;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic        hclk;
  logic        hresetn;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        ho0, ho3;
  logic        hr0, hr3;
  logic [31:0] rd0, rd3;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          act = 0;  // 0: drive the 0-wait DUT, 1: the 3-wait DUT

  logic [31:0] m0 [WORDS0];
  logic [31:0] m3 [WORDS3];
  beat_t       q[$];

  assign hready = act ? ho3 : ho0;

  ahb_sram_responder #(.MEM_WORDS(WORDS0), .WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(ho0), .HRESP(hr0),
    .HRDATA(rd0)
  );

  ahb_sram_responder #(.MEM_WORDS(WORDS3), .WAIT_STATES(3)) u_dut3 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel3), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(ho3), .HRESP(hr3),
    .HRDATA(rd3)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int words_now();
    return act ? WORDS3 : WORDS0;
  endfunction

  function automatic bit mdl_err(input beat_t b);
    bit e;
    e = ((b.addr >> 2) >= 32'(words_now()));
    if (b.size > 3'd2) e = 1;
    if (b.size == 3'd1 && (b.addr % 2) != 0) e = 1;
    if (b.size == 3'd2 && (b.addr % 4) != 0) e = 1;
    return e;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] addr);
    int idx;
    idx = int'(addr >> 2);
    return act ? m3[idx] : m0[idx];
  endfunction

  task automatic mdl_wr(input beat_t b);
    int idx, nb, first;
    logic [31:0] w;
    idx   = int'(b.addr >> 2);
    nb    = 1 << b.size;
    first = int'(b.addr % 4);
    w     = act ? m3[idx] : m0[idx];
    for (int k = 0; k < nb; k++) w[8*(first+k) +: 8] = b.wdata[8*(first+k) +: 8];
    if (act) m3[idx] = w; else m0[idx] = w;
  endtask

  // ---------------- master ----------------
  task automatic push(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.sel = sel; b.trans = tr; b.wr = wr; b.size = sz; b.addr = a; b.wdata = d;
    q.push_back(b);
  endtask

  // Runs the queued beats pipelined, then one IDLE beat, checking each data phase
  task automatic run_seq();
    beat_t cur, prv;
    bit    have_prv;
    int    waits, exp_waits, n;
    bit    resp_bad, rd_unstable, xfer, err;
    logic  ro, rs;
    logic [31:0] rd, first_rd;
    have_prv = 0;
    n = q.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) cur = q[i];
      else begin
        cur.sel = 0; cur.trans = 2'b00; cur.wr = 0; cur.size = 3'd2;
        cur.addr = 32'd0; cur.wdata = 32'd0;
      end
      hsel0  = (!act) && cur.sel;
      hsel3  = act && cur.sel;
      htrans = cur.trans;
      hwrite = cur.wr;
      hsize  = cur.size;
      haddr  = cur.addr;
      hburst = 3'($urandom_range(0, 7));
      hwdata = have_prv ? prv.wdata : $urandom;
      waits = 0; resp_bad = 0; rd_unstable = 0; first_rd = 32'd0;
      forever begin
        @(negedge hclk);
        ro = act ? ho3 : ho0;
        rs = act ? hr3 : hr0;
        rd = act ? rd3 : rd0;
        if (waits == 0) first_rd = rd;
        else if (rd !== first_rd) rd_unstable = 1;
        if (ro) break;
        waits++;
        if (have_prv && (rs !== (prv.sel && prv.trans[1] && mdl_err(prv)))) resp_bad = 1;
        if (waits > 40) break;
      end
      check("ready_bound", 32'(waits > 40), 32'd0);
      if (have_prv) begin
        xfer = prv.sel && prv.trans[1];
        err  = xfer && mdl_err(prv);
        exp_waits = !xfer ? 0 : (err ? 1 : (act ? 3 : 0));
        check("waits", 32'(waits), 32'(exp_waits));
        check("hresp", 32'(rs), 32'(err));
        if (waits > 0) check("wait_resp", 32'(resp_bad), 32'd0);
        if (xfer && !err && !prv.wr) begin
          check("rdata", rd, mdl_rd(prv.addr));
          if (waits > 0) check("rd_stable", 32'(rd_unstable), 32'd0);
        end
        if (xfer && !err && prv.wr) mdl_wr(prv);
      end
      @(posedge hclk);
      #1;
      prv = cur;
      have_prv = 1;
    end
    q.delete();
  endtask

  task automatic push_random(input int count);
    int w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [1:0]  tr;
    w = words_now();
    for (int k = 0; k < count; k++) begin
      sz = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = 32'($urandom_range(0, w*4 - 1));
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = 32'(w*4) + 32'($urandom_range(0, 255));
      tr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) tr[1] = 1'b1;
      push(1'($urandom_range(0, 7) != 0), tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
    end
  endtask

  initial begin
    hresetn = 0; hsel0 = 0; hsel3 = 0; haddr = 0; htrans = 0;
    hwrite = 0; hsize = 0; hburst = 0; hwdata = 0;
    repeat (3) @(posedge hclk);
    #1;
    check("rst_ready0", 32'(ho0), 32'd1);
    check("rst_resp0",  32'(hr0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_ready3", 32'(ho3), 32'd1);
    check("rst_resp3",  32'(hr3), 32'd0);
    check("rst_rdata3", rd3, 32'd0);
    @(negedge hclk) hresetn = 1;
    @(posedge hclk);
    #1;

    // Fill both arrays so every later read has a known value
    act = 0;
    for (int k = 0; k < WORDS0; k++) push(1, 2'b10, 1, 3'd2, 32'(k*4), $urandom);
    run_seq();
    act = 1;
    for (int k = 0; k < WORDS3; k++) push(1, 2'b11, 1, 3'd2, 32'(k*4), $urandom);
    run_seq();

    act = 0;
    // Back-to-back write then read of the same word (forwarding)
    push(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    push(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
    run_seq();
    // Byte merge into an existing word, read straight behind it
    push(1, 2'b10, 1, 3'd2, 32'h10, 32'h11223344);
    push(1, 2'b10, 1, 3'd0, 32'h13, 32'hAA000000);
    push(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
    run_seq();
    // Error transfers: out of range word, misaligned halfword, then readback
    push(1, 2'b10, 1, 3'd2, 32'(WORDS0*4), 32'hFFFFFFFF);
    push(1, 2'b10, 1, 3'd1, 32'h01, 32'hFFFFFFFF);
    push(1, 2'b10, 0, 3'd2, 32'h00, 32'h0);
    push(1, 2'b10, 0, 3'd2, 32'(WORDS0*4), 32'h0);
    run_seq();
    // INCR4 write with a BUSY beat in the middle, then read back
    push(1, 2'b10, 1, 3'd2, 32'h20, 32'hA0A0A0A0);
    push(1, 2'b11, 1, 3'd2, 32'h24, 32'hB1B1B1B1);
    push(1, 2'b01, 1, 3'd2, 32'h28, 32'h0BAD0BAD);
    push(1, 2'b11, 1, 3'd2, 32'h28, 32'hC2C2C2C2);
    push(1, 2'b11, 1, 3'd2, 32'h2C, 32'hD3D3D3D3);
    for (int k = 0; k < 4; k++) push(1, 2'b10, 0, 3'd2, 32'(32'h20 + k*4), 32'h0);
    run_seq();
    push_random(300);
    run_seq();

    act = 1;
    // Wait-state read, write/read, errors and random traffic
    push(1, 2'b10, 0, 3'd2, 32'h08, 32'h0);
    push(1, 2'b10, 1, 3'd1, 32'h0A, 32'h5A5A1234);
    push(1, 2'b10, 0, 3'd2, 32'h08, 32'h0);
    push(1, 2'b10, 1, 3'd2, 32'(WORDS3*4), 32'h0);
    push(1, 2'b10, 0, 3'd2, 32'h40, 32'h0);
    run_seq();
    push_random(150);
    push(1, 2'b10, 0, 3'd2, 32'h40, 32'h0);
    run_seq();

    // Reset pulsed during the wait phase of a write
    hsel3 = 1; htrans = 2'b10; hwrite = 1; hsize = 3'd2; haddr = 32'h40;
    @(negedge hclk);
    check("pre_acc_ready", 32'(ho3), 32'd1);
    @(posedge hclk);
    #1;
    hsel3 = 0; htrans = 2'b00; hwdata = ~m3[16];
    @(negedge hclk);
    check("in_wait_ready", 32'(ho3), 32'd0);
    hresetn = 0;
    #1;
    check("mid_rst_ready", 32'(ho3), 32'd1);
    check("mid_rst_resp",  32'(hr3), 32'd0);
    check("mid_rst_rdata", rd3, 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk) hresetn = 1;
    @(posedge hclk);
    #1;
    push(1, 2'b10, 0, 3'd2, 32'h40, 32'h0);
    push(1, 2'b10, 1, 3'd2, 32'h44, 32'h13572468);
    push(1, 2'b10, 0, 3'd2, 32'h44, 32'h0);
    run_seq();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
